// File: rtl/game_lcd_pkg.sv
// Shared constants, state/screen encodings and character helpers for the
// game LCD writer and its character map.
package game_lcd_pkg;

  // HD44780 command bytes
  localparam logic [7:0] CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_LINE1    = 8'h80;
  localparam logic [7:0] CMD_LINE2    = 8'hC0;

  localparam logic [7:0] ASCII_SPACE  = 8'h20;
  localparam logic [7:0] ASCII_ZERO   = 8'h30;
  localparam logic [7:0] ASCII_QMARK  = 8'h3F;

  localparam logic [1:0] INIT_LAST_IDX  = 2'd3;
  localparam logic [5:0] FRAME_LAST_IDX = 6'd33;
  localparam logic [5:0] LINE2_CMD_IDX  = 6'd17;
  localparam logic [5:0] LINE2_COL0_IDX = 6'd18;

  typedef enum logic [2:0] {
    ST_PWAIT    = 3'd0,
    ST_INIT     = 3'd1,
    ST_FRAME    = 3'd2,
    ST_WRITE    = 3'd3,
    ST_GAP_WAIT = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    SCR_PLAY   = 2'd0,
    SCR_READY  = 2'd1,
    SCR_FAIL   = 2'd2,
    SCR_ALLCLR = 2'd3
  } screen_t;

  // STATE3 = {ALL_CLEAR, LEVEL_FAIL, LEVEL_CLEAR}; multi-hot resolves high bit first.
  function automatic screen_t screen_sel(input logic [2:0] st3);
    if (st3[2]) return SCR_ALLCLR;
    if (st3[1]) return SCR_FAIL;
    if (st3[0]) return SCR_READY;
    return SCR_PLAY;
  endfunction

  function automatic logic [7:0] digit_ascii(input logic [3:0] v, input logic blank_zero);
    if (blank_zero && (v == 4'd0)) return ASCII_SPACE;
    if (v > 4'd9) return ASCII_QMARK;
    return ASCII_ZERO + {4'd0, v};
  endfunction

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return CMD_FUNC_SET;
      2'd1:    return CMD_DISP_ON;
      2'd2:    return CMD_ENTRY;
      default: return CMD_CLEAR;
    endcase
  endfunction

endpackage

// File: rtl/game_lcd_charmap.sv
// Combinational character generator: fixed screen text plus digit fields
// substituted from the frame snapshot.
module game_lcd_charmap
  import game_lcd_pkg::*;
(
  input  screen_t    i_screen,
  input  logic       i_line,
  input  logic [3:0] i_col,
  input  logic [3:0] i_level,
  input  logic [3:0] i_g10,
  input  logic [3:0] i_g1,
  input  logic [3:0] i_p10,
  input  logic [3:0] i_p1,
  input  logic [3:0] i_count_down,
  output logic [7:0] o_char
);

  // Templates carry a space wherever a digit field is overlaid below.
  localparam logic [127:0] S_PLAY1  = "LEVEL   GOAL    ";
  localparam logic [127:0] S_PLAY2  = "PUSH     TIME   ";
  localparam logic [127:0] S_READY1 = "   GET READY    ";
  localparam logic [127:0] S_READY2 = "    LEVEL       ";
  localparam logic [127:0] S_FAIL1  = "   GAME  OVER   ";
  localparam logic [127:0] S_CLR1   = "  ALL  CLEAR!!  ";
  localparam logic [127:0] S_PRESS  = "PRESS 4 BUTTONS ";

  logic [127:0] w_str;

  always_comb begin
    w_str = S_PLAY1;
    case (i_screen)
      SCR_PLAY:   w_str = i_line ? S_PLAY2  : S_PLAY1;
      SCR_READY:  w_str = i_line ? S_READY2 : S_READY1;
      SCR_FAIL:   w_str = i_line ? S_PRESS  : S_FAIL1;
      SCR_ALLCLR: w_str = i_line ? S_PRESS  : S_CLR1;
      default:    w_str = S_PLAY1;
    endcase

    // Column 0 is the leftmost character, i.e. the most significant byte.
    o_char = w_str[{~i_col, 3'b000} +: 8];

    if ((i_screen == SCR_PLAY) && !i_line) begin
      if (i_col == 4'd6)  o_char = digit_ascii(i_level, 1'b0);
      if (i_col == 4'd13) o_char = digit_ascii(i_g10, 1'b1);
      if (i_col == 4'd14) o_char = digit_ascii(i_g1, 1'b0);
    end
    if ((i_screen == SCR_PLAY) && i_line) begin
      if (i_col == 4'd5)  o_char = digit_ascii(i_p10, 1'b1);
      if (i_col == 4'd6)  o_char = digit_ascii(i_p1, 1'b0);
      if (i_col == 4'd14) o_char = digit_ascii(i_count_down, 1'b0);
    end
    if ((i_screen == SCR_READY) && i_line && (i_col == 4'd10)) begin
      o_char = digit_ascii(i_level, 1'b0);
    end
  end

endmodule

// File: rtl/game_lcd_writer.sv
// 16x2 character-LCD writer: power-up wait, init commands, then endless
// full-screen refresh from a per-frame snapshot of the game status.
module game_lcd_writer
  import game_lcd_pkg::*;
#(
  parameter int PWR_WAIT = 30,
  parameter int CLR_WAIT = 2,
  parameter int GAP      = 100
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [2:0] STATE3,
  input  logic [3:0] LEVEL,
  input  logic [3:0] G10,
  input  logic [3:0] G1,
  input  logic [3:0] P10,
  input  logic [3:0] P1,
  input  logic [3:0] COUNT_DOWN,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic [7:0] LCD_DATA,
  output logic       FRAME_DONE,
  output state_t     o_dbg_state
);

  localparam logic [15:0] PWR_LAST = 16'(PWR_WAIT - 1);
  localparam logic [15:0] CLR_LAST = 16'(CLR_WAIT - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP - 1);

  state_t      r_state;
  logic [1:0]  r_phase;
  logic [5:0]  r_idx;
  logic [15:0] r_wait;
  logic        r_clr;
  logic        r_e;
  logic        r_rs;
  logic [7:0]  r_data;
  logic        r_fd;

  logic [2:0]  r_snap_st3;
  logic [3:0]  r_snap_level;
  logic [3:0]  r_snap_g10;
  logic [3:0]  r_snap_g1;
  logic [3:0]  r_snap_p10;
  logic [3:0]  r_snap_p1;
  logic [3:0]  r_snap_cd;

  state_t      w_nxt_state;
  logic [1:0]  w_nxt_phase;
  logic [5:0]  w_nxt_idx;
  logic [15:0] w_nxt_wait;
  logic        w_nxt_clr;
  logic        w_snap_en;
  logic        w_nxt_byte;
  logic        w_line;
  logic [3:0]  w_col;
  logic [7:0]  w_char;
  logic        w_byte_rs;
  logic [7:0]  w_byte_data;
  screen_t     w_screen;

  // r_phase steps 0 -> 1 -> 2 for every byte; r_clr marks the post-clear hold.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_phase = r_phase;
    w_nxt_idx   = r_idx;
    w_nxt_wait  = r_wait;
    w_nxt_clr   = r_clr;
    w_snap_en   = 1'b0;
    case (r_state)
      ST_PWAIT: begin
        if (r_wait == PWR_LAST) begin
          w_nxt_state = ST_INIT;
          w_nxt_phase = 2'd0;
          w_nxt_idx   = 6'd0;
          w_nxt_wait  = 16'd0;
          w_nxt_clr   = 1'b0;
        end else begin
          w_nxt_wait = r_wait + 16'd1;
        end
      end
      ST_INIT: begin
        if (r_clr) begin
          if (r_wait == CLR_LAST) begin
            w_nxt_state = ST_FRAME;
            w_nxt_clr   = 1'b0;
          end else begin
            w_nxt_wait = r_wait + 16'd1;
          end
        end else if (r_phase != 2'd2) begin
          w_nxt_phase = r_phase + 2'd1;
        end else begin
          w_nxt_phase = 2'd0;
          if (r_idx[1:0] == INIT_LAST_IDX) begin
            w_nxt_wait = 16'd0;
            if (CLR_WAIT == 0) w_nxt_state = ST_FRAME;
            else               w_nxt_clr   = 1'b1;
          end else begin
            w_nxt_idx = r_idx + 6'd1;
          end
        end
      end
      ST_FRAME: begin
        w_snap_en   = 1'b1;
        w_nxt_state = ST_WRITE;
        w_nxt_phase = 2'd0;
        w_nxt_idx   = 6'd0;
      end
      ST_WRITE: begin
        if (r_phase != 2'd2) begin
          w_nxt_phase = r_phase + 2'd1;
        end else begin
          w_nxt_phase = 2'd0;
          if (r_idx == FRAME_LAST_IDX) begin
            w_nxt_state = ST_GAP_WAIT;
            w_nxt_wait  = 16'd0;
          end else begin
            w_nxt_idx = r_idx + 6'd1;
          end
        end
      end
      ST_GAP_WAIT: begin
        if (r_wait == GAP_LAST) w_nxt_state = ST_FRAME;
        else                    w_nxt_wait  = r_wait + 16'd1;
      end
      default: begin
        w_nxt_state = ST_PWAIT;
        w_nxt_wait  = 16'd0;
      end
    endcase
  end

  assign w_nxt_byte = ((w_nxt_state == ST_INIT) && !w_nxt_clr) || (w_nxt_state == ST_WRITE);
  assign w_screen   = screen_sel(r_snap_st3);
  assign w_line     = (w_nxt_idx >= LINE2_COL0_IDX);
  assign w_col      = w_line ? 4'(w_nxt_idx - LINE2_COL0_IDX) : 4'(w_nxt_idx - 6'd1);

  game_lcd_charmap u_charmap (
    .i_screen     (w_screen),
    .i_line       (w_line),
    .i_col        (w_col),
    .i_level      (r_snap_level),
    .i_g10        (r_snap_g10),
    .i_g1         (r_snap_g1),
    .i_p10        (r_snap_p10),
    .i_p1         (r_snap_p1),
    .i_count_down (r_snap_cd),
    .o_char       (w_char)
  );

  // Byte about to enter phase 0; frame index 0 and 17 are the cursor commands.
  always_comb begin
    w_byte_rs   = 1'b0;
    w_byte_data = 8'h00;
    if (w_nxt_state == ST_INIT) begin
      w_byte_data = init_cmd(w_nxt_idx[1:0]);
    end else if (w_nxt_idx == 6'd0) begin
      w_byte_data = CMD_LINE1;
    end else if (w_nxt_idx == LINE2_CMD_IDX) begin
      w_byte_data = CMD_LINE2;
    end else begin
      w_byte_rs   = 1'b1;
      w_byte_data = w_char;
    end
  end

  // Outputs are registered from the next-state decode so they line up with r_phase.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state      <= ST_PWAIT;
      r_phase      <= 2'd0;
      r_idx        <= 6'd0;
      r_wait       <= 16'd0;
      r_clr        <= 1'b0;
      r_e          <= 1'b0;
      r_rs         <= 1'b0;
      r_data       <= 8'h00;
      r_fd         <= 1'b0;
      r_snap_st3   <= 3'd0;
      r_snap_level <= 4'd0;
      r_snap_g10   <= 4'd0;
      r_snap_g1    <= 4'd0;
      r_snap_p10   <= 4'd0;
      r_snap_p1    <= 4'd0;
      r_snap_cd    <= 4'd0;
    end else begin
      r_state <= w_nxt_state;
      r_phase <= w_nxt_phase;
      r_idx   <= w_nxt_idx;
      r_wait  <= w_nxt_wait;
      r_clr   <= w_nxt_clr;
      r_e     <= w_nxt_byte && (w_nxt_phase == 2'd1);
      r_fd    <= (r_state == ST_WRITE) && (w_nxt_state == ST_GAP_WAIT);
      if (w_nxt_byte && (w_nxt_phase == 2'd0)) begin
        r_rs   <= w_byte_rs;
        r_data <= w_byte_data;
      end
      if (w_snap_en) begin
        r_snap_st3   <= STATE3;
        r_snap_level <= LEVEL;
        r_snap_g10   <= G10;
        r_snap_g1    <= G1;
        r_snap_p10   <= P10;
        r_snap_p1    <= P1;
        r_snap_cd    <= COUNT_DOWN;
      end
    end
  end

  assign LCD_E       = r_e;
  assign LCD_RS      = r_rs;
  assign LCD_RW      = 1'b0;
  assign LCD_DATA    = r_data;
  assign FRAME_DONE  = r_fd;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_game_lcd_writer.sv
// Bench for game_lcd_writer: init sequence, screen text for directed and
// random status values, snapshot timing, FRAME_DONE and mid-byte reset.
module tb_game_lcd_writer;
  import game_lcd_pkg::*;

  localparam int PWR_WAIT  = 30;
  localparam int CLR_WAIT  = 2;
  localparam int GAP       = 100;
  localparam int E_TIMEOUT = 250;
  localparam int N_DIR     = 8;
  localparam int N_FRAMES  = 12;

  typedef struct {
    int st3;
    int lvl;
    int g10;
    int g1;
    int p10;
    int p1;
    int cd;
  } fin_t;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [2:0] STATE3;
  logic [3:0] LEVEL, G10, G1, P10, P1, COUNT_DOWN;
  logic       LCD_E, LCD_RS, LCD_RW, FRAME_DONE;
  logic [7:0] LCD_DATA;
  state_t     dbg_state;

  int         n_assert = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         last_rise;
  fin_t       frames[N_FRAMES];
  logic [8:0] exp_q[$];

  game_lcd_writer #(.PWR_WAIT(PWR_WAIT), .CLR_WAIT(CLR_WAIT), .GAP(GAP)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .STATE3     (STATE3),
    .LEVEL      (LEVEL),
    .G10        (G10),
    .G1         (G1),
    .P10        (P10),
    .P1         (P1),
    .COUNT_DOWN (COUNT_DOWN),
    .LCD_E      (LCD_E),
    .LCD_RS     (LCD_RS),
    .LCD_RW     (LCD_RW),
    .LCD_DATA   (LCD_DATA),
    .FRAME_DONE (FRAME_DONE),
    .o_dbg_state(dbg_state)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic fin_t mk(input int st3, lvl, g10, g1, p10, p1, cd);
    fin_t f;
    f.st3 = st3; f.lvl = lvl; f.g10 = g10; f.g1 = g1;
    f.p10 = p10; f.p1 = p1; f.cd = cd;
    return f;
  endfunction

  task automatic apply(input fin_t f);
    STATE3     = 3'(f.st3);
    LEVEL      = 4'(f.lvl);
    G10        = 4'(f.g10);
    G1         = 4'(f.g1);
    P10        = 4'(f.p10);
    P1         = 4'(f.p1);
    COUNT_DOWN = 4'(f.cd);
  endtask

  // Reference text, written straight from the screen descriptions.
  function automatic string dch(input int v, input bit blank);
    if (blank && v == 0) return " ";
    if (v > 9) return "?";
    return $sformatf("%0d", v);
  endfunction

  function automatic string exp_line(input fin_t f, input int line);
    if (f.st3 >= 4) return (line == 0) ? "  ALL  CLEAR!!  " : "PRESS 4 BUTTONS ";
    if (f.st3 >= 2) return (line == 0) ? "   GAME  OVER   " : "PRESS 4 BUTTONS ";
    if (f.st3 == 1)
      return (line == 0) ? "   GET READY    " : $sformatf("    LEVEL %s     ", dch(f.lvl, 0));
    if (line == 0)
      return $sformatf("LEVEL %s GOAL %s%s ", dch(f.lvl, 0), dch(f.g10, 1), dch(f.g1, 0));
    return $sformatf("PUSH %s%s  TIME %s ", dch(f.p10, 1), dch(f.p1, 0), dch(f.cd, 0));
  endfunction

  // Waits for the next E pulse and checks the whole 3-cycle byte against exp9.
  task automatic capture_byte(input string tag, input logic [8:0] exp9, input int exp_delta);
    int         waited;
    logic [8:0] prev;
    waited = 0;
    prev   = '0;
    do begin
      @(negedge CLK);
      waited++;
      if (LCD_E !== 1'b1) prev = {LCD_RS, LCD_DATA};
    end while (LCD_E !== 1'b1 && waited < E_TIMEOUT);
    chk({tag, "_e_seen"}, 32'(LCD_E), 32'd1);
    chk({tag, "_delta"}, 32'(cyc - last_rise), 32'(exp_delta));
    last_rise = cyc;
    chk({tag, "_ph0"}, 32'(prev), 32'(exp9));
    chk({tag, "_ph1"}, 32'({LCD_RS, LCD_DATA}), 32'(exp9));
    @(negedge CLK);
    chk({tag, "_ph2_e"}, 32'(LCD_E), 32'd0);
    chk({tag, "_ph2"}, 32'({LCD_RS, LCD_DATA}), 32'(exp9));
  endtask

  // Call right after RESET is released on a falling edge.
  task automatic run_init();
    last_rise = cyc;
    capture_byte("init_38", {1'b0, 8'h38}, PWR_WAIT + 1);
    capture_byte("init_0c", {1'b0, 8'h0C}, 3);
    capture_byte("init_06", {1'b0, 8'h06}, 3);
    capture_byte("init_01", {1'b0, 8'h01}, 3);
  endtask

  task automatic run_frame(input int k, input int first_delta);
    string l1, l2;
    byte   c;
    int    change_at;
    l1 = exp_line(frames[k], 0);
    l2 = exp_line(frames[k], 1);
    exp_q.delete();
    exp_q.push_back({1'b0, 8'h80});
    for (int i = 0; i < 16; i++) begin c = l1[i]; exp_q.push_back({1'b1, 8'(c)}); end
    exp_q.push_back({1'b0, 8'hC0});
    for (int i = 0; i < 16; i++) begin c = l2[i]; exp_q.push_back({1'b1, 8'(c)}); end
    change_at = (k < N_DIR) ? 10 : int'($urandom_range(1, 34));
    for (int b = 0; b < 34; b++) begin
      capture_byte($sformatf("f%0d_b%0d", k, b), exp_q.pop_front(), (b == 0) ? first_delta : 3);
      if (b + 1 == change_at && k + 1 < N_FRAMES) apply(frames[k + 1]);
    end
    chk($sformatf("f%0d_rw", k), 32'(LCD_RW), 32'd0);
    chk($sformatf("f%0d_fd_pre", k), 32'(FRAME_DONE), 32'd0);
    @(negedge CLK);
    chk($sformatf("f%0d_fd_pulse", k), 32'(FRAME_DONE), 32'd1);
    chk($sformatf("f%0d_gap_state", k), 32'(dbg_state), 32'(ST_GAP_WAIT));
    @(negedge CLK);
    chk($sformatf("f%0d_fd_post", k), 32'(FRAME_DONE), 32'd0);
  endtask

  initial begin
    int w;
    frames[0] = mk(0, 3, 3, 0, 1, 7, 4);
    frames[1] = mk(0, 1, 0, 5, 0, 5, 9);
    frames[2] = mk(0, 5, 12, 8, 2, 12, 0);
    frames[3] = mk(2, 4, 1, 2, 3, 4, 5);
    frames[4] = mk(6, 4, 1, 2, 3, 4, 5);
    frames[5] = mk(1, 2, 0, 0, 0, 0, 0);
    frames[6] = mk(0, 2, 2, 5, 1, 3, 7);
    frames[7] = mk(0, 2, 2, 5, 1, 4, 7);
    for (int k = N_DIR; k < N_FRAMES; k++) begin
      frames[k] = mk(($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 7)),
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 15))
                                                 : int'($urandom_range(1, 5)),
                     int'($urandom_range(0, 11)), int'($urandom_range(0, 11)),
                     int'($urandom_range(0, 11)), int'($urandom_range(0, 11)),
                     int'($urandom_range(0, 11)));
    end

    RESET = 1'b1;
    apply(frames[0]);
    repeat (3) @(negedge CLK);
    chk("rst_e", 32'(LCD_E), 32'd0);
    chk("rst_rs", 32'(LCD_RS), 32'd0);
    chk("rst_rw", 32'(LCD_RW), 32'd0);
    chk("rst_data", 32'(LCD_DATA), 32'd0);
    chk("rst_fd", 32'(FRAME_DONE), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ST_PWAIT));

    RESET = 1'b0;
    run_init();
    for (int k = 0; k < N_FRAMES; k++) begin
      run_frame(k, (k == 0) ? (3 + CLR_WAIT + 1) : (GAP + 4));
    end

    // Reset while E is high, then the whole power-up sequence again.
    w = 0;
    do begin
      @(negedge CLK);
      w++;
    end while (LCD_E !== 1'b1 && w < E_TIMEOUT);
    chk("mid_e_seen", 32'(LCD_E), 32'd1);
    RESET = 1'b1;
    @(negedge CLK);
    chk("mid_rst_e", 32'(LCD_E), 32'd0);
    chk("mid_rst_data", 32'(LCD_DATA), 32'd0);
    chk("mid_rst_rs", 32'(LCD_RS), 32'd0);
    chk("mid_rst_fd", 32'(FRAME_DONE), 32'd0);
    chk("mid_rst_state", 32'(dbg_state), 32'(ST_PWAIT));
    apply(frames[0]);
    RESET = 1'b0;
    run_init();
    run_frame(0, 3 + CLR_WAIT + 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
